// File: rtl/iomem_rr_arbiter.sv
// Two-master round-robin arbiter for a single iomem-style valid/ready slave.
// Grant is held for the whole transaction; a watchdog forces completion on a dead slave.
module iomem_rr_arbiter #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic          WDOG_EN  = (TIMEOUT > 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic in_busy;
    logic gvalid;
    logic done;
    logic expire;

    assign in_busy = (state_q == BUSY);
    assign gvalid  = grant_q ? m1_valid : m0_valid;
    // An abandoned request or a cycle under reset never produces a ready pulse.
    assign done    = in_busy && gvalid && resetn && s_ready;
    assign expire  = in_busy && gvalid && resetn && !s_ready && WDOG_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_valid || m1_valid) begin
                    state_d = BUSY;
                    grant_d = (m0_valid && m1_valid) ? !last_grant_q : m1_valid;
                end
            end
            BUSY: begin
                if (!gvalid) begin
                    state_d = IDLE;
                end else if (done || expire) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic [31:0] rdata;
        rdata       = done ? s_rdata : (expire ? ERR_RDATA : '0);
        s_valid     = in_busy;
        s_wstrb     = grant_q ? m1_wstrb : m0_wstrb;
        s_addr      = grant_q ? m1_addr  : m0_addr;
        s_wdata     = grant_q ? m1_wdata : m0_wdata;
        m0_ready    = (done || expire) && !grant_q;
        m1_ready    = (done || expire) &&  grant_q;
        m0_rdata    = !grant_q ? rdata : '0;
        m1_rdata    =  grant_q ? rdata : '0;
        grant       = grant_q;
        busy        = in_busy;
        timeout_err = expire;
    end

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
// Directed bench for iomem_rr_arbiter with TIMEOUT=8 and hand-computed expectations.
module tb_iomem_rr_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        grant, busy, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    iomem_rr_arbiter #(
        .TIMEOUT   (8),
        .ERR_RDATA (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_wstrb    (m0_wstrb),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_wstrb    (m1_wstrb),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_svalid", 32'(s_valid), 32'd0);
        check("rst_rdy0",   32'(m0_ready), 32'd0);
        check("rst_rdy1",   32'(m1_ready), 32'd0);
        check("rst_grant",  32'(grant), 32'd0);
        check("rst_terr",   32'(timeout_err), 32'd0);
        resetn = 1'b1;
    endtask

    // Called in IDLE with requests already applied; returns in the IDLE cycle after completion.
    task automatic serve(input string tag, input logic g, input int lat, input logic [31:0] rd);
        tick();
        check({tag, "_busy"},   32'(busy), 32'd1);
        check({tag, "_svalid"}, 32'(s_valid), 32'd1);
        check({tag, "_grant"},  32'(grant), 32'(g));
        for (int i = 1; i < lat; i++) begin
            check({tag, "_early_rdy"}, 32'(g ? m1_ready : m0_ready), 32'd0);
            tick();
        end
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        check({tag, "_rdy"},       32'(g ? m1_ready : m0_ready), 32'd1);
        check({tag, "_rdata"},     g ? m1_rdata : m0_rdata, rd);
        check({tag, "_oth_rdy"},   32'(g ? m0_ready : m1_ready), 32'd0);
        check({tag, "_oth_rdata"}, g ? m0_rdata : m1_rdata, 32'd0);
        check({tag, "_terr"},      32'(timeout_err), 32'd0);
        tick();
        s_ready = 1'b0;
        s_rdata = '0;
        #1;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_sv"},   32'(s_valid), 32'd0);
        check({tag, "_idle_rdy"},  32'(m0_ready | m1_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        resetn   = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_wstrb = '0;   m1_wstrb = '0;
        m0_addr  = '0;   m1_addr  = '0;
        m0_wdata = '0;   m1_wdata = '0;
        s_ready  = 1'b0; s_rdata  = '0;

        do_reset();

        // Single read, slave answers on the 4th BUSY cycle
        m0_addr  = 32'h0300_0010;
        m0_wstrb = 4'b0000;
        m0_valid = 1'b1;
        #1;
        check("rd_sv_before", 32'(s_valid), 32'd0);
        serve("rd", 1'b0, 4, 32'h1234_5678);
        m0_valid = 1'b0;

        // Contention from reset: 0,1,0,1,0,1
        do_reset();
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int k = 0; k < 6; k++)
            serve($sformatf("rr%0d", k), logic'(k % 2), 1 + (k % 3), 32'h100 + 32'(k));
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        // Write passthrough from m1 while m0 waits with different bus values
        m1_addr  = 32'h0300_0040;  m1_wstrb = 4'b0101;  m1_wdata = 32'hA5A5_5A5A;
        m0_addr  = 32'h0300_0080;  m0_wstrb = 4'b1111;  m0_wdata = 32'h1111_2222;
        m1_valid = 1'b1;
        tick();
        check("wr_grant", 32'(grant), 32'd1);
        m0_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("wr_saddr",  s_addr, 32'h0300_0040);
            check("wr_swstrb", 32'(s_wstrb), 32'h5);
            check("wr_swdata", s_wdata, 32'hA5A5_5A5A);
            check("wr_rdy0",   32'(m0_ready), 32'd0);
            tick();
        end
        s_ready = 1'b1;
        #1;
        check("wr_rdy1", 32'(m1_ready), 32'd1);
        check("wr_rdy0_done", 32'(m0_ready), 32'd0);
        tick();
        s_ready  = 1'b0;
        m1_valid = 1'b0;
        serve("wr_m0", 1'b0, 2, 32'h0BAD_F00D);

        // Watchdog expiry on the 8th BUSY cycle, m1 pending
        tick();
        check("to_grant", 32'(grant), 32'd0);
        m1_valid = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            check("to_terr_early", 32'(timeout_err), 32'd0);
            check("to_rdy_early",  32'(m0_ready), 32'd0);
            tick();
        end
        check("to_rdy0",  32'(m0_ready), 32'd1);
        check("to_rdata", m0_rdata, 32'hFFFF_FFFF);
        check("to_terr",  32'(timeout_err), 32'd1);
        check("to_rdy1",  32'(m1_ready), 32'd0);
        tick();
        m0_valid = 1'b0;
        #1;
        check("to_sv_after",   32'(s_valid), 32'd0);
        check("to_terr_after", 32'(timeout_err), 32'd0);
        serve("to_m1", 1'b1, 1, 32'h5555_AAAA);
        m1_valid = 1'b0;

        // s_ready exactly on the expiry cycle wins
        m0_valid = 1'b1;
        serve("edge", 1'b0, 8, 32'hCAFE_F00D);
        m0_valid = 1'b0;

        // Granted master abandons its request: no ready, last grant unchanged (still 0)
        m1_valid = 1'b1;
        tick();
        check("abort_grant", 32'(grant), 32'd1);
        m1_valid = 1'b0;
        s_ready  = 1'b1;
        #1;
        check("abort_rdy1", 32'(m1_ready), 32'd0);
        check("abort_rdy0", 32'(m0_ready), 32'd0);
        tick();
        s_ready = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        serve("abort_rr", 1'b1, 1, 32'h0000_00A1);
        m1_valid = 1'b0;

        // Leave last grant at 0, then reset mid-transaction
        serve("pre_rst", 1'b0, 1, 32'h0000_00B2);
        tick();
        check("mrst_grant", 32'(grant), 32'd0);
        resetn  = 1'b0;
        s_ready = 1'b1;
        #1;
        check("mrst_rdy0", 32'(m0_ready), 32'd0);
        tick();
        s_ready = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_sv",   32'(s_valid), 32'd0);
        resetn   = 1'b1;
        m1_valid = 1'b1;
        serve("mrst_rr", 1'b0, 1, 32'h0000_00C3);
        m0_valid = 1'b0;
        m1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_rr_arbiter.md
Name: iomem_rr_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC's valid/ready memory bus.
- Shares a single iomem-style slave (SPRAM bank, audio buffer, peripheral window) between the CPU iomem port and a second bus master such as a DMA or audio engine.
- Round-robin fairness; grant held for the whole transaction.
- Bus-timeout watchdog so a dead slave cannot hang either master.

Parameters:
TIMEOUT, 64, max BUSY cycles before forced completion; 0 disables the watchdog
ERR_RDATA, 32'hFFFF_FFFF, read data returned on a timed-out transaction

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active-low
m0_valid  input  1  master 0 request, held until m0_ready
m0_wstrb  input  4  master 0 byte write strobes; 0 = read
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_ready  output  1  master 0 transaction complete (1-cycle pulse)
m0_rdata  output  32  master 0 read data, valid with m0_ready
m1_valid, m1_wstrb, m1_addr, m1_wdata, m1_ready, m1_rdata  same widths/directions/meaning, master 1
s_valid  output  1  slave request
s_wstrb  output  4  slave strobes
s_addr  output  32  slave address
s_wdata  output  32  slave write data
s_ready  input  1  slave completion pulse
s_rdata  input  32  slave read data, valid with s_ready
grant  output  1  currently granted master (meaningful while busy)
busy  output  1  transaction in flight
timeout_err  output  1  1-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on resetn.
- Reset values: state=IDLE, busy=0, s_valid=0, m*_ready=0, timeout_err=0, grant=0, last_grant=1 (master 0 wins the first contention), counter=0.
- State machine: IDLE, BUSY.
- IDLE:
  - If exactly one m*_valid is high, register grant to that master and go to BUSY.
  - If both are high, grant = !last_grant.
  - If neither is high, stay in IDLE.
  - s_valid=0 and all m*_ready=0 in IDLE.
- BUSY:
  - s_valid=1. s_wstrb/s_addr/s_wdata are combinationally muxed from the granted master.
  - The non-granted master sees ready=0 and its request simply waits.
- Completion:
  - In BUSY with s_ready=1: m[grant]_ready=1 and m[grant]_rdata=s_rdata in the same cycle (combinational).
  - Next state is IDLE; last_grant<=grant.
- Latency: s_valid rises 1 cycle after m_valid is first seen in IDLE. Minimum transaction is 2 cycles (request seen, then slave ready in the first BUSY cycle). There is always at least one IDLE cycle between transactions, so no re-arbitration happens in the completion cycle.
- Back-to-back: with both masters continuously requesting, grants strictly alternate 0,1,0,1...
- Non-granted rdata outputs: drive 0. The granted rdata output is 0 except in its ready cycle.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the counter reaches TIMEOUT-1 with s_ready=0: m[grant]_ready=1, m[grant]_rdata=ERR_RDATA, timeout_err=1 for that cycle, s_valid deasserts next cycle, state goes to IDLE, last_grant updated.
  - s_ready in the expiry cycle takes precedence: normal completion, no error.
- Protocol violation: if the granted master drops valid while in BUSY, return to IDLE next cycle with no ready pulse and last_grant unchanged.
- Reset mid-transaction: resetn=0 in BUSY forces IDLE at the next edge, s_valid=0, and no ready pulse is generated.
- Writes and reads are treated identically. The arbiter neither inspects nor modifies wstrb/addr/wdata.

Test Plan:
- Single read: m0_valid, addr 0x0300_0010, wstrb 0; slave ready 3 cycles after s_valid with rdata 0x1234_5678 -> s_valid rises 1 cycle after m0_valid; m0_ready pulses once with m0_rdata=0x1234_5678; m1_ready stays 0.
- Contention after reset: both masters assert in the same cycle -> m0 granted first, m1 granted on the next IDLE; grant sequence over 6 transactions = 0,1,0,1,0,1.
- Write passthrough: m1 writes wstrb 4'b0101, wdata 0xA5A5_5A5A -> slave sees identical s_wstrb/s_wdata/s_addr while BUSY; m0 signals never appear on the slave bus.
- Timeout: TIMEOUT=8, slave never ready -> m0_ready and timeout_err pulse on the 8th BUSY cycle; m0_rdata=0xFFFF_FFFF; s_valid low the next cycle; a pending m1 request is granted afterwards.
- Boundary: s_ready arrives exactly on the 8th BUSY cycle (TIMEOUT=8) -> normal completion with slave data, timeout_err=0.
- Reset mid-operation: resetn low in BUSY -> next cycle busy=0, s_valid=0, no ready pulse; after release, a contended request grants m0 first.
